// File: rtl/onfi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : onfi_pkg
//  Description : Shared types and constants for the ONFI init/reset path:
//                init controller state encoding, reset opcode and default
//                timing values.
//  Revision    : 1.0 - initial release
// ============================================================================
package onfi_pkg;

    // Init controller states
    typedef enum logic [2:0] {
        PWRUP    = 3'd0,
        ISSUE    = 3'd1,
        WAIT_SEQ = 3'd2,
        TWB      = 3'd3,
        WAIT_RDY = 3'd4,
        FAIL     = 3'd5,
        DONE     = 3'd6,
        ERR      = 3'd7
    } onfi_init_state_e;

    // ONFI RESET opcode, also used by the reset command sequencer
    localparam logic [7:0] CMD_RESET = 8'hFF;

    // Default timing, in onfi_clk cycles
    localparam int DEF_POWERUP_WAIT = 10000;
    localparam int DEF_TWB_CYCLES   = 8;
    localparam int DEF_RDY_TIMEOUT  = 50000;
    localparam int DEF_RETRY_MAX    = 3;
    localparam int DEF_CNT_W        = 16;

    // 2-bit increment that sticks at 3
    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        return (v == 2'd3) ? v : v + 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/onfi_sync2.sv
`default_nettype none
// ============================================================================
//  Module      : onfi_sync2
//  Description : Two-flop synchroniser with a configurable reset (preset)
//                value, for asynchronous pad inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module onfi_sync2 #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/onfi_init_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : onfi_init_ctrl
//  Description : ONFI power-up / re-init controller. Waits out power-up,
//                kicks the reset command sequencer, waits tWB, then polls
//                R/B# with per-state timeout and bounded retry.
//  Revision    : 1.0 - initial release
// ============================================================================
module onfi_init_ctrl
    import onfi_pkg::*;
#(
    parameter int POWERUP_WAIT = DEF_POWERUP_WAIT,
    parameter int TWB_CYCLES   = DEF_TWB_CYCLES,
    parameter int RDY_TIMEOUT  = DEF_RDY_TIMEOUT,
    parameter int RETRY_MAX    = DEF_RETRY_MAX,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic       onfi_clk,
    input  logic       onfi_rst_n,
    input  logic       init_req,
    input  logic       onfi_rbn,
    output logic       rst_seq_start,
    input  logic       rst_seq_done,
    output logic       init_busy,
    output logic       init_done,
    output logic       init_err,
    output logic [1:0] retry_cnt
);

    localparam logic [CNT_W-1:0] C_PWRUP_LAST = CNT_W'(POWERUP_WAIT - 1);
    localparam logic [CNT_W-1:0] C_TWB_LAST   = CNT_W'(TWB_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_TMO_LAST   = CNT_W'(RDY_TIMEOUT - 1);

    onfi_init_state_e r_state;
    onfi_init_state_e w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_retry_cnt;
    logic [1:0]       w_retry_next;
    logic [1:0]       w_retry_inc;
    logic             w_rdy_s;
    logic             w_counting;
    logic             r_rst_seq_start;
    logic             r_init_busy;
    logic             r_init_done;
    logic             r_init_err;

    // R/B# resynchronised; preset to busy so nothing looks ready out of reset
    onfi_sync2 #(
        .WIDTH     (1),
        .RESET_VAL (1'b0)
    ) u_rbn_sync (
        .clk   (onfi_clk),
        .rst_n (onfi_rst_n),
        .i_d   (onfi_rbn),
        .o_q   (w_rdy_s)
    );

    assign w_counting  = (r_state == PWRUP) || (r_state == WAIT_SEQ) ||
                         (r_state == TWB)   || (r_state == WAIT_RDY);
    assign w_retry_inc = sat_inc2(r_retry_cnt);

    // Next-state and retry-count decision
    always_comb begin
        w_next_state = r_state;
        w_retry_next = r_retry_cnt;
        case (r_state)
            PWRUP: begin
                if (r_cnt == C_PWRUP_LAST) w_next_state = ISSUE;
            end
            ISSUE: begin
                w_next_state = WAIT_SEQ;
            end
            WAIT_SEQ: begin
                if (rst_seq_done)              w_next_state = TWB;
                else if (r_cnt == C_TMO_LAST)  w_next_state = FAIL;
            end
            TWB: begin
                if (r_cnt == C_TWB_LAST) w_next_state = WAIT_RDY;
            end
            WAIT_RDY: begin
                // Ready takes priority over a coincident timeout
                if (w_rdy_s)                   w_next_state = DONE;
                else if (r_cnt == C_TMO_LAST)  w_next_state = FAIL;
            end
            FAIL: begin
                w_retry_next = w_retry_inc;
                w_next_state = (int'(w_retry_inc) < RETRY_MAX) ? ISSUE : ERR;
            end
            DONE, ERR: begin
                if (init_req) begin
                    w_retry_next = 2'd0;
                    w_next_state = ISSUE;
                end
            end
            default: begin
                w_next_state = PWRUP;
            end
        endcase
    end

    // State, shared counter, retry count and registered status outputs
    always_ff @(posedge onfi_clk or negedge onfi_rst_n) begin
        if (!onfi_rst_n) begin
            r_state         <= PWRUP;
            r_cnt           <= '0;
            r_retry_cnt     <= 2'd0;
            r_rst_seq_start <= 1'b0;
            r_init_busy     <= 1'b1;
            r_init_done     <= 1'b0;
            r_init_err      <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_retry_cnt <= w_retry_next;
            if (w_next_state != r_state)
                r_cnt <= '0;
            else if (w_counting && (r_cnt != '1))
                r_cnt <= r_cnt + 1'b1;
            r_rst_seq_start <= (w_next_state == ISSUE);
            r_init_done     <= (w_next_state == DONE);
            r_init_err      <= (w_next_state == ERR);
            r_init_busy     <= (w_next_state != DONE) && (w_next_state != ERR);
        end
    end

    assign rst_seq_start = r_rst_seq_start;
    assign init_busy     = r_init_busy;
    assign init_done     = r_init_done;
    assign init_err      = r_init_err;
    assign retry_cnt     = r_retry_cnt;

endmodule
`default_nettype wire

// File: tb/tb_onfi_init_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_onfi_init_ctrl
//  Description : Self-checking bench for onfi_init_ctrl with a sequencer
//                model, R/B# model and start/result scoreboard queues.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_onfi_init_ctrl;

    logic       clk;
    logic       onfi_rst_n;
    logic       init_req;
    logic       onfi_rbn;
    logic       rst_seq_start;
    logic       rst_seq_done;
    logic       init_busy;
    logic       init_done;
    logic       init_err;
    logic [1:0] retry_cnt;

    onfi_init_ctrl #(
        .POWERUP_WAIT (10),
        .TWB_CYCLES   (4),
        .RDY_TIMEOUT  (20),
        .RETRY_MAX    (2),
        .CNT_W        (16)
    ) dut (
        .onfi_clk      (clk),
        .onfi_rst_n    (onfi_rst_n),
        .init_req      (init_req),
        .onfi_rbn      (onfi_rbn),
        .rst_seq_start (rst_seq_start),
        .rst_seq_done  (rst_seq_done),
        .init_busy     (init_busy),
        .init_done     (init_done),
        .init_err      (init_err),
        .retry_cnt     (retry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit seq_ok;      // sequencer answers start with done 5 cycles later
        int rbn_attempt; // R/B# rises 6 cycles after done of this attempt (0 = always high)
        bit stray;       // stray done pulses in PWRUP and in the ISSUE cycle
        int start1;
        int start2;      // -1 = no second start
        bit exp_done;
        bit exp_err;
        int exp_retry;
        int exp_cycle;   // cycle init_busy first reads low
    } vec_t;

    typedef struct {
        bit exp_done;
        bit exp_err;
        int exp_retry;
        int exp_cycle;
    } res_t;

    int   n_cmp;
    int   n_bad;
    int   cyc;
    int   attempt;
    int   done_at;
    int   rbn_at;
    int   req_at;
    bit   g_seq_ok;
    int   g_rbn_attempt;
    bit   g_stray;
    int   start_q[$];
    res_t res_q[$];
    vec_t vecs[5];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_start"}, int'(rst_seq_start), 0);
        chk({tag, "_done"},  int'(init_done),     0);
        chk({tag, "_err"},   int'(init_err),      0);
        chk({tag, "_busy"},  int'(init_busy),     1);
        chk({tag, "_retry"}, int'(retry_cnt),     0);
    endtask

    // One clock: sample DUT, run scoreboard and models, drive next inputs
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        rst_seq_done = 1'b0;
        init_req     = 1'b0;
        chk("flag_consistency", int'({init_busy, init_done & init_err}),
            int'({~(init_done | init_err), 1'b0}));
        if (rst_seq_start) begin
            n_cmp++;
            if (start_q.size() == 0) begin
                n_bad++;
                $display("FAIL start_unexpected: got start at cycle %0d, want none", cyc);
            end else begin
                int exp_c;
                exp_c = start_q.pop_front();
                n_cmp--;
                chk("start_cycle", cyc, exp_c);
            end
            attempt++;
            if (g_seq_ok) done_at = cyc + 5;
        end
        if (g_stray && (cyc == 5 || cyc == 10)) rst_seq_done = 1'b1;
        if (cyc == done_at) begin
            rst_seq_done = 1'b1;
            if (attempt == g_rbn_attempt) rbn_at = cyc + 6;
        end
        if (cyc == rbn_at) onfi_rbn = 1'b1;
        if (cyc == req_at) init_req = 1'b1;
    endtask

    task automatic begin_run(input bit seq_ok, input int rbn_attempt, input bit stray);
        onfi_rst_n    = 1'b0;
        init_req      = 1'b0;
        rst_seq_done  = 1'b0;
        g_seq_ok      = seq_ok;
        g_rbn_attempt = rbn_attempt;
        g_stray       = stray;
        onfi_rbn      = (rbn_attempt == 0);
        attempt       = 0;
        done_at       = -1;
        rbn_at        = -1;
        req_at        = -1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        onfi_rst_n = 1'b1;
        cyc        = 0;
    endtask

    task automatic expect_run(input int s1, input int s2, input bit d, input bit e,
                              input int r, input int c);
        res_t rr;
        start_q.push_back(s1);
        if (s2 >= 0) start_q.push_back(s2);
        rr.exp_done  = d;
        rr.exp_err   = e;
        rr.exp_retry = r;
        rr.exp_cycle = c;
        res_q.push_back(rr);
    endtask

    task automatic run_until(input int c);
        while (cyc < c) step();
    endtask

    // Wait for completion, then compare against the oldest expected result
    task automatic finish_run(input string tag);
        int   budget;
        res_t rr;
        budget = 300;
        while (init_busy && budget > 0) begin
            step();
            budget--;
        end
        if (budget == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got busy still 1 at cycle %0d, want 0", tag, cyc);
        end
        if (res_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_scoreboard: got no expected result queued, want one", tag);
        end else begin
            rr = res_q.pop_front();
            chk({tag, "_end_cycle"}, cyc,             rr.exp_cycle);
            chk({tag, "_done"},      int'(init_done), int'(rr.exp_done));
            chk({tag, "_err"},       int'(init_err),  int'(rr.exp_err));
            chk({tag, "_retry"},     int'(retry_cnt), rr.exp_retry);
        end
        chk({tag, "_missing_starts"}, start_q.size(), 0);
    endtask

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        cyc          = 0;
        onfi_rst_n   = 1'b0;
        init_req     = 1'b0;
        onfi_rbn     = 1'b0;
        rst_seq_done = 1'b0;

        //        seq rbnA stray s1  s2  done err retry end
        vecs[0] = '{1'b1, 1, 1'b0, 10, -1, 1'b1, 1'b0, 0, 24}; // nominal
        vecs[1] = '{1'b1, 0, 1'b0, 10, -1, 1'b1, 1'b0, 0, 21}; // early ready
        vecs[2] = '{1'b1, 2, 1'b0, 10, 41, 1'b1, 1'b0, 1, 55}; // timeout, recover
        vecs[3] = '{1'b0, 1, 1'b0, 10, 32, 1'b0, 1'b1, 2, 54}; // hard failure
        vecs[4] = '{1'b0, 1, 1'b1, 10, 32, 1'b0, 1'b1, 2, 54}; // stray done ignored

        for (int i = 0; i < 5; i++) begin
            begin_run(vecs[i].seq_ok, vecs[i].rbn_attempt, vecs[i].stray);
            expect_run(vecs[i].start1, vecs[i].start2, vecs[i].exp_done,
                       vecs[i].exp_err, vecs[i].exp_retry, vecs[i].exp_cycle);
            finish_run($sformatf("vec%0d", i));
        end

        // Request during WAIT_RDY is ignored; request in DONE re-runs with retry cleared
        begin_run(1'b1, 2, 1'b0);
        expect_run(10, 41, 1'b1, 1'b0, 1, 55);
        req_at = 52;
        finish_run("reinit_ignored");
        req_at = 57;
        expect_run(58, -1, 1'b1, 1'b0, 0, 69);
        run_until(58);
        chk("reinit_retry_cleared", int'(retry_cnt), 0);
        finish_run("reinit_done");

        // Request in ERR re-runs the retry loop from zero
        begin_run(1'b0, 1, 1'b0);
        expect_run(10, 32, 1'b0, 1'b1, 2, 54);
        finish_run("err_first");
        req_at = 56;
        expect_run(57, 79, 1'b0, 1'b1, 2, 101);
        run_until(57);
        chk("err_reinit_retry_cleared", int'(retry_cnt), 0);
        finish_run("err_reinit");

        // Reset during TWB of the second attempt, then a full power-up again
        begin_run(1'b1, 2, 1'b0);
        start_q.push_back(10);
        start_q.push_back(41);
        run_until(48);
        chk("midreset_retry_before", int'(retry_cnt), 1);
        onfi_rst_n = 1'b0;
        #2;
        chk_reset_vals("midreset_async");
        chk("midreset_queue", start_q.size(), 0);
        begin_run(1'b1, 1, 1'b0);
        expect_run(10, -1, 1'b1, 1'b0, 0, 24);
        finish_run("after_midreset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/onfi_init_ctrl.md
Name: onfi_init_ctrl

Overview:
- Power-up and re-initialisation controller directly upstream of the ONFI reset command sequencer.
- Enforces the power-on wait, then pulses the sequencer's start and waits for its done.
- Then waits tWB and polls the device R/B# line until ready, with timeout and bounded retry.
- Reports init_done or init_err to the controller top; the read/program datapath stays gated until init_done.

Parameters:
- POWERUP_WAIT, 10000: onfi_clk cycles from reset release to the first reset command.
- TWB_CYCLES, 8: cycles after rst_seq_done before R/B# is sampled.
- RDY_TIMEOUT, 50000: maximum cycles in each wait state (sequencer done, R/B# ready).
- RETRY_MAX, 3: reset attempts before declaring an error; minimum 1.
- CNT_W, 16: width of the shared cycle counter; must hold max(POWERUP_WAIT, RDY_TIMEOUT).

Ports:
- onfi_clk  in  1  controller clock; all logic on the rising edge.
- onfi_rst_n  in  1  asynchronous, active-low reset.
- init_req  in  1  level; a request to re-run init, honoured only in DONE or ERR.
- onfi_rbn  in  1  device R/B# (0 = busy); asynchronous to onfi_clk.
- rst_seq_start  out  1  one-cycle start pulse to the reset sequencer.
- rst_seq_done  in  1  one-cycle pulse from the sequencer when the FFh command has been issued and CE# released.
- init_busy  out  1  high in every state except DONE and ERR.
- init_done  out  1  high in DONE.
- init_err  out  1  high in ERR.
- retry_cnt  out  2  attempts used so far; saturates at 3.

Behaviour:
- Reset (async assert, synchronous-release domain):
  - state = PWRUP, counter = 0, retry_cnt = 0.
  - rst_seq_start = 0, init_done = 0, init_err = 0, init_busy = 1.
  - Synchroniser flops preset to 0 (busy).
- onfi_rbn passes through a 2-flop synchroniser; rdy_s is the synchronised value. Its latency is 2 cycles, which is included in all timing below.
- Counter: cleared on every state entry, increments each cycle in a counting state, never wraps.
- PWRUP: count; when counter == POWERUP_WAIT-1 go to ISSUE.
- ISSUE: assert rst_seq_start for exactly this one cycle, then go to WAIT_SEQ.
- WAIT_SEQ:
  - rst_seq_done = 1 -> TWB.
  - Otherwise, counter == RDY_TIMEOUT-1 -> FAIL.
- TWB: count; when counter == TWB_CYCLES-1 go to WAIT_RDY. rdy_s is ignored here, so ready before tWB has no effect.
- WAIT_RDY:
  - rdy_s = 1 -> DONE.
  - Otherwise, counter == RDY_TIMEOUT-1 -> FAIL.
  - If both occur in the same cycle, ready wins.
- FAIL (one cycle): retry_cnt increments.
  - New value < RETRY_MAX -> ISSUE, skipping the power-up wait.
  - Otherwise -> ERR.
- DONE: init_done = 1, outputs held. init_req = 1 -> clear retry_cnt, go to ISSUE.
- ERR: init_err = 1, held. init_req = 1 -> clear retry_cnt, go to ISSUE.
- init_req in any other state is ignored; there is no queueing.
- rst_seq_done arriving outside WAIT_SEQ is ignored.
- A stray rst_seq_done in the same cycle as ISSUE is ignored; only pulses in WAIT_SEQ count.
- Reset asserted mid-sequence returns to PWRUP and drops rst_seq_start immediately. The sequencer is reset by the same onfi_rst_n.
- All outputs are registered; init_done, init_err and init_busy are decoded from the state register and are mutually consistent every cycle.

Decomposition:
- Shared package onfi_pkg holds:
  - the state enum (PWRUP, ISSUE, WAIT_SEQ, TWB, WAIT_RDY, FAIL, DONE, ERR);
  - the ONFI command opcode constant CMD_RESET = 8'hFF, shared with the sequencer;
  - default timing constants.
- One natural sub-module: onfi_sync2, the 2-flop synchroniser with preset value, reused for the other asynchronous pad inputs.

Test Plan (bench parameters POWERUP_WAIT=10, TWB_CYCLES=4, RDY_TIMEOUT=20, RETRY_MAX=2):
- Nominal: release reset; the sequencer model returns done 5 cycles after start; R/B# goes high 6 cycles after done.
  - rst_seq_start pulses once, at cycle 10 after release.
  - init_done rises and init_busy falls; retry_cnt = 0.
- Early ready: hold R/B# high throughout.
  - TWB still lasts 4 cycles; init_done rises the cycle after TWB ends.
- Timeout then recover: R/B# stays low through the first attempt and goes high during the second.
  - Exactly 2 start pulses, no second power-up wait; init_done = 1, retry_cnt = 1.
- Hard failure: the sequencer never returns done.
  - Two start pulses, 20 cycles of WAIT_SEQ each; init_err = 1, retry_cnt = 2, init_busy = 0.
- Re-init and ignored request: pulse init_req in DONE, and also once during WAIT_RDY.
  - The DONE request produces a start pulse the next cycle with retry_cnt cleared.
  - The WAIT_RDY request has no effect.
- Mid-operation reset: assert onfi_rst_n low during TWB.
  - All outputs return to reset values asynchronously; after release the full 10-cycle power-up wait repeats.
